// File: rtl/noc_pkg.sv
// Shared constants, flit layout and state encoding for the NoC local-port injector.
package noc_pkg;

  localparam logic [1:0] DEST_EAST    = 2'b00;
  localparam logic [1:0] DEST_WEST    = 2'b01;
  localparam logic [1:0] DEST_LOCAL   = 2'b10;
  localparam logic [1:0] DEST_ILLEGAL = 2'b11;

  localparam int FLIT_W      = 16;
  localparam int FLIT_VLD    = 0;
  localparam int FLIT_DST_LO = 1;
  localparam int FLIT_DST_HI = 2;
  localparam int FLIT_PLD_LO = 3;
  localparam int PLD_W       = FLIT_W - FLIT_PLD_LO;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_STALL = 2'b10
  } inj_state_t;

  // Packs a destination and payload into a flit with the valid bit set.
  function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0]       dest,
                                                  input logic [PLD_W-1:0] payload);
    logic [FLIT_W-1:0] f;
    f                          = '0;
    f[FLIT_VLD]                = 1'b1;
    f[FLIT_DST_HI:FLIT_DST_LO] = dest;
    f[FLIT_W-1:FLIT_PLD_LO]    = payload;
    return f;
  endfunction

endpackage

// File: rtl/noc_inj_queue.sv
// Show-ahead synchronous FIFO holding formatted flits awaiting injection.
module noc_inj_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push & (!full | pop);
  assign do_pop  = pop & !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_local_injector.sv
// Transmit side of a router Local port: formats tile requests into flits, queues
// them and writes them to the router FIFO while respecting full/almost-full flags.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_dest,
  input  logic [PLD_W-1:0]  req_payload,
  output logic              writeL,
  output logic [FLIT_W-1:0] dataInL,
  input  logic              fullL,
  input  logic              almost_fullL,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              q_full;
  logic              q_empty;
  logic [FLIT_W-1:0] q_dout;
  logic [FLIT_W-1:0] flit;
  logic              accept;
  logic              illegal;
  logic              push;
  logic              can_send;
  inj_state_t        state;
  inj_state_t        next_state;

  assign req_ready = !q_full;
  assign accept    = req_valid & req_ready;
  assign illegal   = (req_dest == DEST_ILLEGAL);
  assign push      = accept & !illegal;
  assign flit      = make_flit(req_dest, req_payload);

  // A write last cycle may have consumed the router's final free slot, so
  // almost-full blocks the next write until the flag catches up.
  assign can_send  = !q_empty & !fullL & !(almost_fullL & writeL);

  assign busy      = (state != ST_IDLE) | writeL;

  noc_inj_queue #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (can_send),
    .din   (flit),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  // Registered write strobe and data; an idle bus carries all zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeL  <= 1'b0;
      dataInL <= '0;
    end else begin
      writeL  <= can_send;
      dataInL <= can_send ? q_dout : '0;
    end
  end

  // Saturating statistics for flits written and illegal requests discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (can_send && sent_cnt != CNT_MAX)             sent_cnt <= sent_cnt + CNT_ONE;
      if (accept && illegal && drop_cnt != CNT_MAX)    drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  // Injector state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state: idle once nothing is queued or arriving, otherwise issue or stall.
  always_comb begin
    next_state = state;
    if (q_empty && !push) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  next_state = ST_ISSUE;
        ST_ISSUE: next_state = (can_send || q_empty) ? ST_ISSUE : ST_STALL;
        ST_STALL: next_state = (can_send || q_empty) ? ST_ISSUE : ST_STALL;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_local_injector.sv
// Randomized and directed bench for noc_local_injector with a queue-based reference model.
module tb_noc_local_injector;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_dest;
  logic [12:0] req_payload;
  logic        fullL;
  logic        almost_fullL;

  logic        req_ready;
  logic        writeL;
  logic [15:0] dataInL;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;
  logic        busy;

  logic        sat_req_ready;
  logic        sat_writeL;
  logic [15:0] sat_data;
  logic [1:0]  sat_sent;
  logic [1:0]  sat_drop;
  logic        sat_busy;

  int check_count = 0;
  int pass_count  = 0;

  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic        model_writeL;
  int          model_sent;
  int          model_drop;
  logic        prev_idle;

  noc_local_injector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dest     (req_dest),
    .req_payload  (req_payload),
    .writeL       (writeL),
    .dataInL      (dataInL),
    .fullL        (fullL),
    .almost_fullL (almost_fullL),
    .sent_cnt     (sent_cnt),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  noc_local_injector #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (sat_req_ready),
    .req_dest     (req_dest),
    .req_payload  (req_payload),
    .writeL       (sat_writeL),
    .dataInL      (sat_data),
    .fullL        (fullL),
    .almost_fullL (almost_fullL),
    .sent_cnt     (sat_sent),
    .drop_cnt     (sat_drop),
    .busy         (sat_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic [12:0] p,
                               input logic f, input logic af);
    req_valid    = v;
    req_dest     = d;
    req_payload  = p;
    fullL        = f;
    almost_fullL = af;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_val(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Reference model: compare current outputs, then advance by one clock edge.
  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
      exp_q.delete();
      model_writeL = 1'b0;
      model_sent   = 0;
      model_drop   = 0;
      prev_idle    = 1'b1;
    end else begin
      logic cur_idle;
      logic send;
      int   occ;
      checkOutput("writeL", {31'd0, writeL}, {31'd0, model_writeL});
      checkOutput("sat writeL", {31'd0, sat_writeL}, {31'd0, model_writeL});
      if (!model_writeL) checkOutput("idle dataInL", {16'd0, dataInL}, 32'd0);
      checkOutput("req_ready", {31'd0, req_ready}, {31'd0, model_q.size() < DEPTH});
      checkOutput("sat req_ready", {31'd0, sat_req_ready}, {31'd0, model_q.size() < DEPTH});
      checkOutput("sent_cnt", {16'd0, sent_cnt}, sat_val(model_sent, 65535));
      checkOutput("drop_cnt", {16'd0, drop_cnt}, sat_val(model_drop, 65535));
      checkOutput("sat sent_cnt", {30'd0, sat_sent}, sat_val(model_sent, 3));
      checkOutput("sat drop_cnt", {30'd0, sat_drop}, sat_val(model_drop, 3));
      cur_idle = (model_q.size() == 0) && !model_writeL;
      if (!cur_idle) checkOutput("busy active", {30'd0, busy, sat_busy}, 32'd3);
      else if (prev_idle) checkOutput("busy idle", {30'd0, busy, sat_busy}, 32'd0);
      prev_idle = cur_idle;

      occ  = model_q.size();
      send = (occ > 0) && !fullL && !(almost_fullL && model_writeL);
      if (send) begin
        exp_q.push_back(model_q.pop_front());
        model_sent++;
      end
      model_writeL = send;
      if (req_valid && occ < DEPTH) begin
        if (req_dest == 2'b11) model_drop++;
        else model_q.push_back({req_payload, req_dest, 1'b1});
      end
    end
  end

  // Scoreboard monitor: every flit the DUT writes must be the next one expected.
  always @(negedge clk) begin
    if (!reset && writeL) begin
      if (exp_q.size() == 0) checkOutput("unexpected write", {16'd0, dataInL}, 32'd0);
      else checkOutput("flit order", {16'd0, dataInL}, {16'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    req_valid = 1'b0; req_dest = 2'b00; req_payload = '0; fullL = 1'b0; almost_fullL = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset writeL", {31'd0, writeL}, 32'd0);
    checkOutput("reset dataInL", {16'd0, dataInL}, 32'd0);
    checkOutput("reset counters", {sent_cnt, drop_cnt}, 32'd0);
    checkOutput("reset ready/busy", {30'd0, req_ready, busy}, 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] single request");
    applyStimulus(1'b1, 2'b01, 13'h0ABC, 1'b0, 1'b0);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (writeL) break;
    end
    checkOutput("t1 flit", {16'd0, dataInL}, 32'h55E3);
    repeat (3) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);
    checkOutput("t1 sent", {16'd0, sent_cnt}, 32'd1);

    $display("[TB] back-to-back");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i % 3), 13'(100 + i), 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);

    $display("[TB] flow control");
    applyStimulus(1'b1, 2'b00, 13'h1111, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 13'h0222, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 13'(i * 7 + 3), 1'b1, 1'b0);
    checkOutput("t3 full ready", {31'd0, req_ready}, 32'd0);
    repeat (6) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);

    $display("[TB] illegal destination");
    applyStimulus(1'b1, 2'b11, 13'h1234, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);
    checkOutput("t4 drop_cnt", {16'd0, drop_cnt}, 32'd1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b10, 13'(200 + i), 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5 writeL async", {31'd0, writeL}, 32'd0);
    checkOutput("t5 dataInL async", {16'd0, dataInL}, 32'd0);
    checkOutput("t5 busy async", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);

    $display("[TB] counter saturation");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b00, 13'(300 + i), 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);
    checkOutput("t6 sat sent", {30'd0, sat_sent}, 32'd3);
    checkOutput("t6 wide sent", {16'd0, sent_cnt}, 32'd5);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      int dsel;
      dsel = $urandom_range(0, 7);
      applyStimulus($urandom_range(0, 9) < 7, (dsel == 7) ? 2'b11 : 2'(dsel % 3),
                    13'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    waited = 0;
    req_valid = 1'b0; fullL = 1'b0; almost_fullL = 1'b0;
    while ((model_q.size() != 0 || exp_q.size() != 0 || writeL) && waited < 50) begin
      applyStimulus(1'b0, 2'b00, 13'h0, 1'b0, 1'b0);
      waited++;
    end
    checkOutput("drain", exp_q.size() + model_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
